pipe_scroller: RTL and testbench

//   Upstream feeder of the colour mapper. Owns the four pipe obstacles and the 2-digit BCD score.

---
 rtl/pipe_scroller.sv | 141 ++++++++++++++
 tb/tb_pipe_scroller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Pipe obstacle scroller and 2-digit BCD score keeper feeding the colour mapper.
// Pipes move once per synchronised frame strobe; the score counts pipes that pass the bird.
module pipe_scroller #(
    parameter logic [12:0] SCROLL_SPEED = 13'd2,
    parameter logic [12:0] PIPE_SPACING = 13'd200,
    parameter logic [12:0] START_X      = 13'd680,
    parameter logic [12:0] PIPE_HALF_W  = 13'd24,
    parameter logic [12:0] GAP_HALF     = 13'd60,
    parameter logic [12:0] GAP_MIN      = 13'd112
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             start,
    input  logic             crash,
    input  logic [9:0]       BirdX,
    output logic [3:0][12:0] pipeX,
    output logic [3:0][12:0] pipeWidth,
    output logic [3:0][12:0] pipeGapSize,
    output logic [3:0][12:0] pipeGapLocation,
    output logic [7:0]       score,
    output logic             score_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} stateT;

    localparam logic [12:0] WRAP_ADD   = 13'(4 * PIPE_SPACING);
    localparam logic [12:0] WRAP_LIMIT = SCROLL_SPEED + PIPE_HALF_W;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    stateT            stateReg, stateNext;
    logic             frameSync1Reg, frameSync2Reg, frameSync3Reg;
    logic             frameTick;
    logic [15:0]      lfsrReg, lfsrNext;
    logic [3:0][12:0] pipeXReg, pipeXNext, gapReg, gapNext;
    logic [3:0][12:0] initX, initGap, stepX, movedX;
    logic [3:0]       wrapPipe, passPipe;
    logic [7:0]       scoreReg, scoreNext, scoreInc;
    logic             pulseReg, pulseNext;
    logic [12:0]      birdX13, spawnGap;

    // Third flop only remembers the previous synced level for edge detection.
    assign frameTick = frameSync2Reg & ~frameSync3Reg;
    assign lfsrNext  = {1'b0, lfsrReg[15:1]} ^ (lfsrReg[0] ? LFSR_MASK : 16'h0000);
    assign birdX13   = {3'b000, BirdX};
    assign spawnGap  = GAP_MIN + {5'b00000, lfsrReg[7:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : genPipe
            assign initX[gi]       = 13'(START_X + gi * PIPE_SPACING);
            assign initGap[gi]     = 13'(GAP_MIN + gi * 64);
            assign stepX[gi]       = pipeXReg[gi] - SCROLL_SPEED;
            assign wrapPipe[gi]    = pipeXReg[gi] <= WRAP_LIMIT;
            // Respawn adds the full ring length so spacing between pipes stays exact.
            assign movedX[gi]      = wrapPipe[gi] ? stepX[gi] + WRAP_ADD : stepX[gi];
            assign passPipe[gi]    = (pipeXReg[gi] > birdX13) && (stepX[gi] <= birdX13);
            assign pipeWidth[gi]   = PIPE_HALF_W;
            assign pipeGapSize[gi] = GAP_HALF;
        end
    endgenerate

    always_comb begin
        scoreInc = scoreReg;
        if (scoreReg[3:0] == 4'd9) begin
            scoreInc = {scoreReg[7:4] + 4'd1, 4'd0};
        end else begin
            scoreInc = {scoreReg[7:4], scoreReg[3:0] + 4'd1};
        end
    end

    always_comb begin
        stateNext = stateReg;
        pipeXNext = pipeXReg;
        gapNext   = gapReg;
        scoreNext = scoreReg;
        pulseNext = 1'b0;
        case (stateReg)
            IDLE: begin
                pipeXNext = initX;
                gapNext   = initGap;
                scoreNext = 8'h00;
                if (start) stateNext = RUN;
            end
            RUN: begin
                // A crash in the same cycle as a frame tick wins: nothing moves.
                if (crash) begin
                    stateNext = HALT;
                end else if (frameTick) begin
                    for (int i = 0; i < 4; i++) begin
                        pipeXNext[i] = movedX[i];
                        if (wrapPipe[i]) gapNext[i] = spawnGap;
                    end
                    if ((|passPipe) && (scoreReg != 8'h99)) begin
                        scoreNext = scoreInc;
                        pulseNext = 1'b1;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    stateNext = IDLE;
                    pipeXNext = initX;
                    gapNext   = initGap;
                    scoreNext = 8'h00;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg      <= IDLE;
            pipeXReg      <= initX;
            gapReg        <= initGap;
            scoreReg      <= 8'h00;
            pulseReg      <= 1'b0;
            lfsrReg       <= LFSR_SEED;
            frameSync1Reg <= 1'b0;
            frameSync2Reg <= 1'b0;
            frameSync3Reg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            pipeXReg      <= pipeXNext;
            gapReg        <= gapNext;
            scoreReg      <= scoreNext;
            pulseReg      <= pulseNext;
            lfsrReg       <= lfsrNext;
            frameSync1Reg <= frame_clk;
            frameSync2Reg <= frameSync1Reg;
            frameSync3Reg <= frameSync2Reg;
        end
    end

    assign pipeX           = pipeXReg;
    assign pipeGapLocation = gapReg;
    assign score           = scoreReg;
    assign score_pulse     = pulseReg;

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: stimulus pushes expected frame updates, a monitor
// pops and compares whenever the pipes, gaps or score visibly change.
module tb_pipe_scroller;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             frame_clk = 1'b0;
    logic             start = 1'b0;
    logic             crash = 1'b0;
    logic [9:0]       BirdX = 10'd0;
    logic [3:0][12:0] pipeX, pipeWidth, pipeGapSize, pipeGapLocation;
    logic [7:0]       score;
    logic             score_pulse;

    pipe_scroller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .crash(crash),
        .BirdX(BirdX), .pipeX(pipeX), .pipeWidth(pipeWidth), .pipeGapSize(pipeGapSize),
        .pipeGapLocation(pipeGapLocation), .score(score), .score_pulse(score_pulse)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0][12:0] px;
        logic [7:0]       score;
        logic             pulse;
        logic [3:0]       gapRand;
        logic             gapInit;
        logic [31:0]      edgeCycle;
        logic [31:0]      latency;
    } expT;

    expT         q[$];
    int          checks = 0;
    int          errors = 0;
    logic        doneReq = 1'b0;
    logic [31:0] cycle = 0;
    logic [15:0] lfsrModel, lfsrUsed;
    int          mPx[4];
    int          mScore;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR; lfsrUsed is the value that was live during the previous cycle.
    always @(posedge Clk) begin
        cycle     <= cycle + 1;
        lfsrUsed  <= lfsrModel;
        lfsrModel <= Reset ? 16'hACE1 : lfsrStep(lfsrModel);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, expv, $time);
        end
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic modelInit();
        for (int i = 0; i < 4; i++) mPx[i] = 680 + 200 * i;
        mScore = 0;
    endtask

    // Spec-level frame step: move left, respawn near the left edge, count any pass once.
    task automatic modelTick(output expT e);
        bit passed;
        int nx;
        e = '0;
        passed = 0;
        for (int i = 0; i < 4; i++) begin
            nx = mPx[i] - 2;
            if (mPx[i] > int'(BirdX) && nx <= int'(BirdX)) passed = 1;
            if (mPx[i] <= 26) begin
                mPx[i] = nx + 800;
                e.gapRand[i] = 1'b1;
            end else begin
                mPx[i] = nx;
            end
            e.px[i] = 13'(mPx[i]);
        end
        e.pulse = passed && (mScore < 99);
        if (e.pulse) mScore++;
        e.score = {4'(mScore / 10), 4'(mScore % 10)};
    endtask

    task automatic chooseBird();
        int j, idx;
        if ($urandom_range(0, 1) == 1) begin
            j = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                idx = (j + k) % 4;
                if (mPx[idx] >= 3 && mPx[idx] <= 1023) begin
                    BirdX = 10'(mPx[idx] - int'($urandom_range(0, 3)));
                    break;
                end
            end
        end else begin
            BirdX = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic frameEdge(input bit expectUpdate);
        expT e;
        if (expectUpdate) begin
            modelTick(e);
            e.edgeCycle = cycle;
            e.latency   = 3;
            q.push_back(e);
        end
        frame_clk = 1'b1;
        waitNeg(3 + int'($urandom_range(0, 2)));
        frame_clk = 1'b0;
        waitNeg(2 + int'($urandom_range(0, 2)));
    endtask

    task automatic pushIdleEntry();
        expT e;
        e = '0;
        for (int i = 0; i < 4; i++) e.px[i] = 13'(680 + 200 * i);
        e.gapInit   = 1'b1;
        e.edgeCycle = cycle;
        e.latency   = 1;
        q.push_back(e);
        modelInit();
    endtask

    // Stimulus
    initial begin
        modelInit();
        waitNeg(3);
        Reset = 1'b0;
        waitNeg(10);
        frameEdge(0);
        frameEdge(0);
        start = 1'b1;
        waitNeg(1);
        start = 1'b0;
        waitNeg(1);
        repeat (300) begin
            chooseBird();
            frameEdge(1);
        end
        // Crash lands in the very cycle the frame tick fires.
        frame_clk = 1'b1;
        waitNeg(2);
        crash = 1'b1;
        waitNeg(1);
        crash = 1'b0;
        waitNeg(2);
        frame_clk = 1'b0;
        waitNeg(3);
        frameEdge(0);
        frameEdge(0);
        // start and crash together: HALT->IDLE, then IDLE->RUN.
        start = 1'b1;
        crash = 1'b1;
        pushIdleEntry();
        waitNeg(2);
        start = 1'b0;
        crash = 1'b0;
        waitNeg(2);
        repeat (900) begin
            chooseBird();
            frameEdge(1);
        end
        // Reset while a frame tick is in flight.
        frame_clk = 1'b1;
        waitNeg(2);
        Reset = 1'b1;
        frame_clk = 1'b0;
        waitNeg(3);
        Reset = 1'b0;
        modelInit();
        waitNeg(5);
        frameEdge(0);
        start = 1'b1;
        waitNeg(1);
        start = 1'b0;
        waitNeg(1);
        repeat (60) begin
            chooseBird();
            frameEdge(1);
        end
        waitNeg(5);
        doneReq = 1'b1;
    end

    // Monitor
    initial begin
        logic [3:0][12:0] lastPx, lastGap;
        logic [7:0]       lastScore;
        logic [12:0]      expGap;
        bit               prevReset;
        expT              e;
        prevReset = 1;
        lastPx    = '0;
        lastGap   = '0;
        lastScore = 8'h00;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prevReset = 1;
                continue;
            end
            if (prevReset) begin
                prevReset = 0;
                for (int i = 0; i < 4; i++) begin
                    lastPx[i]  = 13'(680 + 200 * i);
                    lastGap[i] = 13'(112 + 64 * i);
                    chk("rst_pipeX", i, 32'(pipeX[i]), 32'(lastPx[i]));
                    chk("rst_gap", i, 32'(pipeGapLocation[i]), 32'(lastGap[i]));
                    chk("rst_width", i, 32'(pipeWidth[i]), 32'd24);
                    chk("rst_gapSize", i, 32'(pipeGapSize[i]), 32'd60);
                end
                lastScore = 8'h00;
                chk("rst_score", 0, 32'(score), 32'h00);
                chk("rst_pulse", 0, 32'(score_pulse), 32'd0);
            end
            if (doneReq) begin
                chk("queue_drained", 0, 32'(q.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (pipeX != lastPx || pipeGapLocation != lastGap || score != lastScore || score_pulse) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: pipe0 got %0d (was %0d), score got %h (was %h), pulse %0d (t=%0t)",
                             pipeX[0], lastPx[0], score, lastScore, score_pulse, $time);
                    lastPx    = pipeX;
                    lastGap   = pipeGapLocation;
                    lastScore = score;
                end else begin
                    e = q.pop_front();
                    chk("latency", 0, cycle - e.edgeCycle, e.latency);
                    for (int i = 0; i < 4; i++) begin
                        if (e.gapInit) expGap = 13'(112 + 64 * i);
                        else if (e.gapRand[i]) expGap = 13'd112 + {5'b00000, lfsrUsed[7:0]};
                        else expGap = lastGap[i];
                        chk("pipeX", i, 32'(pipeX[i]), 32'(e.px[i]));
                        chk("gapLoc", i, 32'(pipeGapLocation[i]), 32'(expGap));
                        chk("width", i, 32'(pipeWidth[i]), 32'd24);
                        chk("gapSize", i, 32'(pipeGapSize[i]), 32'd60);
                        lastGap[i] = expGap;
                    end
                    chk("score", 0, 32'(score), 32'(e.score));
                    chk("score_pulse", 0, 32'(score_pulse), 32'(e.pulse));
                    lastPx    = e.px;
                    lastScore = e.score;
                end
            end
        end
    end

endmodule
